data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Multi-cycle data-memory responder serving the MEM stage's load/store requests.
//  It decodes each request's access width from load_mode, holds the pipeline with
//  stall for LATENCY cycles, and then commits the store or returns the
//  sign/zero-extended load data with a one-cycle done pulse.
//  It is the memory-side end of the MEM-stage data interface.
// PARAMETERS
//  DEPTH_LOG2  8   log2 of memory depth in 32-bit words (256 words)
//  LATENCY     2   cycles from accept edge to done; legal range 1..15
// PORTS
//  CLK          in   1   clock, rising edge
//  RST          in   1   synchronous reset, active high
//  mem_read     in   1   load request; held by MEM stage until done
//  mem_write    in   1   store request; held by MEM stage until done
//  address      in   32  byte address
//  write_data   in   32  store data, right-aligned
//  load_mode    in   2   00 word, 01 half signed, 10 byte signed, 11 byte unsigned
//  stall        out  1   combinational; freezes pipeline while access is pending
//  done         out  1   one-cycle pulse: access complete, read_data/misaligned valid
//  read_data    out  32  extended load result; stays valid until the next done
//  misaligned   out  1   valid with done: access rejected for misalignment
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, done=0, read_data=0, misaligned=0. Memory array is
//   not cleared. Reset during BUSY aborts the access: a pending store is never committed.
//  FSM states: IDLE, BUSY, RESP.
//   IDLE: when mem_read|mem_write, the request is accepted at the edge.
//    address, write_data, load_mode and the operation are latched.
//    counter<=LATENCY-1 and state goes to BUSY.
//   BUSY: while counter!=0, counter decrements.
//    At the edge with counter==0, the access is performed and state goes to RESP.
//   RESP: done=1 for exactly one cycle; requests are ignored; next state is IDLE.
//  stall = (IDLE & (mem_read|mem_write)) | BUSY. stall is low in RESP, so the pipeline
//   advances at the RESP edge. done is asserted LATENCY+1 cycles after the accept cycle.
//  mem_read & mem_write together: treated as a store; the read is ignored.
//  Only the latched copy is used; request changes after accept are ignored.
//  Width and alignment: the byte lane is address[1:0], little-endian (lane 0 = bits 7:0).
//   Word needs address[1:0]==0; half needs address[0]==0; byte is always aligned.
//   On a misaligned access: no memory update, read_data<=0, misaligned=1 with done.
//  Store: sw writes all 4 bytes; sh (01) writes 2 lanes from write_data[15:0].
//   sb (10 or 11) writes 1 lane from write_data[7:0]. Other lanes are unchanged.
//  Load: half/byte loads select the lane, then sign-extend (01,10) or zero-extend (11).
//   A store leaves read_data unchanged.
//  Address wrap: word index = address[DEPTH_LOG2+1:2]; upper bits are ignored (modulo depth).
//  A read in the cycle after a store completes returns the newly written data.
//  misaligned is cleared on the next accepted request and held otherwise.
// TESTING
//  T1 Reset: RST high for 2 cycles with mem_read=1.
//   -> stall=0 after reset, done=0, read_data=0.
//  T2 Word store then load, LATENCY=2: sw 0xDEADBEEF to 0x10, then lw 0x10.
//   -> stall high for 3 cycles per access; done pulses; read_data=0xDEADBEEF.
//  T3 Sub-word loads from word 0x80F17F01 at 0x20:
//   byte signed @0x22 -> 0xFFFFFFF1; byte unsigned @0x22 -> 0x000000F1;
//   half signed @0x20 -> 0x00007F01; half signed @0x22 -> 0xFFFF80F1.
//  T4 Misalignment: lw @0x21 and sh @0x23.
//   -> misaligned=1 with done; memory at 0x20 unchanged; read_data=0.
//  T5 Reset mid-access: sw 0x12345678 to 0x40, RST asserted in the 1st BUSY cycle;
//   then lw 0x40 -> previous contents (the store was never committed).
//  T6 Wrap and conflict: with DEPTH_LOG2=8, sb 0xAA @0x400 with mem_read=1 also high.
//   -> treated as a store; lbu @0x000 returns 0x000000AA.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: latches a load/store request,
// stalls the pipeline for LATENCY cycles, then commits the store or returns extended load data.
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [1:0]  load_mode,
  output logic        stall,
  output logic        done,
  output logic [31:0] read_data,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_t                  state;
  logic [3:0]              counter;
  logic [DEPTH_LOG2+1:0]   lat_addr;
  logic [31:0]             lat_wdata;
  logic [1:0]              lat_mode;
  logic                    lat_write;
  logic [31:0]             mem [DEPTH];

  logic                    request;
  logic                    perform;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic [1:0]              lane;
  logic                    access_mis;
  logic [31:0]             cur_word;
  logic [31:0]             shifted;
  logic [31:0]             store_word;
  logic [31:0]             load_word;
  logic                    unused_addr_bits;

  // Upper address bits fold the access onto the array (modulo depth).
  assign unused_addr_bits = ^address[31:DEPTH_LOG2+2];

  assign request = mem_read | mem_write;
  assign perform = (state == BUSY) && (counter == 4'd0);
  assign stall   = ((state == IDLE) && request) || (state == BUSY);
  assign done    = (state == RESP);

  always_comb begin
    word_idx   = lat_addr[DEPTH_LOG2+1:2];
    lane       = lat_addr[1:0];
    cur_word   = mem[word_idx];
    shifted    = cur_word >> {lane, 3'b000};
    access_mis = 1'b0;
    store_word = cur_word;
    load_word  = cur_word;
    case (lat_mode)
      2'b00: begin
        access_mis = (lane != 2'b00);
        store_word = lat_wdata;
      end
      2'b01: begin
        access_mis = lane[0];
        store_word[{lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
        load_word  = {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        store_word[{lane, 3'b000} +: 8] = lat_wdata[7:0];
        load_word = (lat_mode == 2'b10) ? {{24{shifted[7]}}, shifted[7:0]}
                                        : {24'd0, shifted[7:0]};
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      counter    <= '0;
      read_data  <= '0;
      misaligned <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_mode   <= '0;
      lat_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            lat_addr   <= address[DEPTH_LOG2+1:0];
            lat_wdata  <= write_data;
            lat_mode   <= load_mode;
            lat_write  <= mem_write;
            counter    <= 4'(LATENCY - 1);
            misaligned <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            state <= RESP;
            if (access_mis) begin
              misaligned <= 1'b1;
              read_data  <= '0;
            end else if (!lat_write) begin
              read_data <= load_word;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Kept apart from the control block so the array carries no reset; reset still blocks the commit.
  always_ff @(posedge CLK) begin
    if (!RST && perform && lat_write && !access_mis)
      mem[word_idx] <= store_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array memory model predicts each
// response, which is queued at request time and compared when done pulses.
module tb_data_mem_responder;

  localparam int unsigned DEPTH_LOG2 = 8;
  localparam int unsigned LATENCY    = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [1:0]  load_mode;
  logic        stall;
  logic        done;
  logic [31:0] read_data;
  logic        misaligned;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mb [1024];
  logic [31:0] last_rd = '0;
  logic [32:0] sb_q [$];

  data_mem_responder #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .LATENCY   (LATENCY)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .address   (address),
    .write_data(write_data),
    .load_mode (load_mode),
    .stall     (stall),
    .done      (done),
    .read_data (read_data),
    .misaligned(misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered just after a falling edge with the DUT idle; leaves it the same way.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] mode, input string tag);
    logic        mis;
    logic [31:0] exp_rd;
    logic [32:0] exp;
    int          base;
    int          ln;
    int          st;
    bit          got;
    base = int'({addr[9:2], 2'b00});
    ln   = int'(addr[1:0]);
    mis  = (mode == 2'b00 && addr[1:0] != 2'b00) || (mode == 2'b01 && addr[0]);
    if (mis) begin
      exp_rd = '0;
    end else if (wr) begin
      if (mode == 2'b00) begin
        for (int i = 0; i < 4; i++) mb[base + i] = wd[8*i +: 8];
      end else if (mode == 2'b01) begin
        mb[base + ln]     = wd[7:0];
        mb[base + ln + 1] = wd[15:8];
      end else begin
        mb[base + ln] = wd[7:0];
      end
      exp_rd = last_rd;
    end else begin
      if (mode == 2'b00)
        exp_rd = {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
      else if (mode == 2'b01)
        exp_rd = {{16{mb[base + ln + 1][7]}}, mb[base + ln + 1], mb[base + ln]};
      else if (mode == 2'b10)
        exp_rd = {{24{mb[base + ln][7]}}, mb[base + ln]};
      else
        exp_rd = {24'd0, mb[base + ln]};
    end
    last_rd = exp_rd;
    sb_q.push_back({mis, exp_rd});

    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wd;
    load_mode  = mode;
    st  = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (done) begin
        got = 1'b1;
      end else begin
        if (stall) st++;
        @(negedge CLK);
      end
    end
    exp = sb_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_rdata"}, read_data, exp[31:0]);
      check({tag, "_misal"}, {31'd0, misaligned}, {31'd0, exp[32]});
      check({tag, "_stall_cycles"}, st, LATENCY + 1);
      check({tag, "_stall_resp"}, {31'd0, stall}, 32'd0);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge CLK);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    RST        = 1'b1;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    load_mode  = '0;
    repeat (2) @(negedge CLK);
    check("t1_done_in_reset", {31'd0, done}, 32'd0);
    RST      = 1'b0;
    mem_read = 1'b0;
    #1;
    check("t1_stall", {31'd0, stall}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd0);
    check("t1_rdata", read_data, 32'd0);
    check("t1_misal", {31'd0, misaligned}, 32'd0);

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, "t2_sw");
    access(1'b1, 1'b0, 32'h10, 32'h0, 2'b00, "t2_lw");
    check("t2_const", read_data, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'h20, 32'h80F17F01, 2'b00, "t3_sw");
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b10, "t3_lb");
    check("t3_lb_const", read_data, 32'hFFFFFFF1);
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b11, "t3_lbu");
    check("t3_lbu_const", read_data, 32'h000000F1);
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b01, "t3_lh0");
    check("t3_lh0_const", read_data, 32'h00007F01);
    access(1'b1, 1'b0, 32'h22, 32'h0, 2'b01, "t3_lh2");
    check("t3_lh2_const", read_data, 32'hFFFF80F1);

    access(1'b1, 1'b0, 32'h21, 32'h0, 2'b00, "t4_lw_mis");
    access(1'b0, 1'b1, 32'h23, 32'h0000BEEF, 2'b01, "t4_sh_mis");
    access(1'b1, 1'b0, 32'h20, 32'h0, 2'b00, "t4_lw");
    check("t4_unchanged", read_data, 32'h80F17F01);

    access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'b00, "t5_pre");
    mem_write  = 1'b1;
    address    = 32'h40;
    write_data = 32'h12345678;
    load_mode  = 2'b00;
    @(negedge CLK);
    check("t5_busy_stall", {31'd0, stall}, 32'd1);
    RST       = 1'b1;
    mem_write = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("t5_stall", {31'd0, stall}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    last_rd = '0;
    access(1'b1, 1'b0, 32'h40, 32'h0, 2'b00, "t5_lw");
    check("t5_const", read_data, 32'hCAFEF00D);

    access(1'b0, 1'b1, 32'h0, 32'h11223344, 2'b00, "t6_init");
    access(1'b1, 1'b1, 32'h400, 32'h000000AA, 2'b10, "t6_sb_wrap");
    access(1'b1, 1'b0, 32'h0, 32'h0, 2'b11, "t6_lbu");
    check("t6_const", read_data, 32'h000000AA);
    access(1'b1, 1'b0, 32'h0, 32'h0, 2'b00, "t6_lw");

    for (int i = 0; i < 8; i++)
      access(1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 2'b00, "rnd_sw");
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  m;
      logic [31:0] a;
      m = 2'($urandom_range(0, 3));
      a = 32'h100 + 32'($urandom_range(0, 31));
      if (m == 2'b00) a[1:0] = 2'b00;
      if (m == 2'b01) a[0] = 1'b0;
      access(1'b1, 1'b0, a, 32'h0, m, "rnd_ld");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
